// File: rtl/matrix_addsub_seq.sv
// Sequential N x N matrix add/subtract engine: captures A, B and mode on accept,
// then produces LANES ripple add/sub results per cycle until the whole matrix is done.
module matrix_addsub_seq #(
  parameter int W     = 3,
  parameter int N     = 2,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [N*N*W-1:0]       a_flat,
  input  logic [N*N*W-1:0]       b_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N*(W+1)-1:0]   c_flat,
  output logic [N*N-1:0]         cb_mask,
  output logic                   busy
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  generate
    if (LANES < 1 || (NE % LANES) != 0) begin : g_bad_lanes
      $error("matrix_addsub_seq: LANES must divide N*N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NE*W-1:0]       r_a;
  logic [NE*W-1:0]       r_b;
  logic                  r_mode;
  logic [IW-1:0]         r_idx;
  logic [NE*(W+1)-1:0]   r_c;
  logic [NE-1:0]         r_cb;
  logic [W:0]            w_res [LANES];
  logic                  w_last;
  logic                  w_accept;

  // Subtraction reuses the adder: invert B, carry-in 1, and the top bit becomes the borrow.
  function automatic logic [W:0] rippleAddSub(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub);
    logic [W:0] s;
    logic       cy;
    logic       bb;
    s  = '0;
    cy = sub;
    for (int k = 0; k < W; k++) begin
      bb   = b[k] ^ sub;
      s[k] = a[k] ^ bb ^ cy;
      cy   = (a[k] & bb) | (cy & (a[k] ^ bb));
    end
    s[W] = cy ^ sub;
    return s;
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_res[l] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      w_res[l] = rippleAddSub(r_a[(int'(r_idx) + l)*W +: W], r_b[(int'(r_idx) + l)*W +: W], r_mode);
    end
  end

  assign w_last   = (int'(r_idx) == NE - LANES);
  assign w_accept = (r_state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // idx stops on the last group so it never points past element N*N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
      r_idx  <= '0;
      r_c    <= '0;
      r_cb   <= '0;
    end else if (w_accept) begin
      r_a    <= a_flat;
      r_b    <= b_flat;
      r_mode <= mode;
      r_idx  <= '0;
      r_c    <= '0;
      r_cb   <= '0;
    end else if (r_state == RUN) begin
      for (int l = 0; l < LANES; l++) begin
        r_c[(int'(r_idx) + l)*(W+1) +: W+1] <= w_res[l];
        r_cb[int'(r_idx) + l]               <= w_res[l][W];
      end
      if (!w_last) begin
        r_idx <= r_idx + IW'(LANES);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign c_flat    = r_c;
  assign cb_mask   = r_cb;

endmodule
